// File: rtl/ws_pe_if.sv
// Bundled north/west inputs and south/east outputs of one weight-stationary PE.
// The master drives the in_* side; the slave is the PE, which drives out_* and sat_flag.
interface ws_pe_if #(
  parameter int PSUM_W = 24
);
  logic [7:0]        in_w;
  logic              in_w_valid;
  logic              in_w_swap;
  logic [7:0]        out_w;
  logic              out_w_valid;
  logic              out_w_swap;
  logic [7:0]        in_act;
  logic              in_act_valid;
  logic [7:0]        out_act;
  logic              out_act_valid;
  logic [PSUM_W-1:0] in_psum;
  logic              in_psum_valid;
  logic [PSUM_W-1:0] out_psum;
  logic              out_psum_valid;
  logic              sat_flag;

  // Valids are plain per-cycle qualifiers; there is no ready or backpressure.
  // The whole array stalls together through the global en input.
  modport master (
    output in_w, in_w_valid, in_w_swap, in_act, in_act_valid, in_psum, in_psum_valid,
    input  out_w, out_w_valid, out_w_swap, out_act, out_act_valid, out_psum,
           out_psum_valid, sat_flag
  );

  modport slave (
    input  in_w, in_w_valid, in_w_swap, in_act, in_act_valid, in_psum, in_psum_valid,
    output out_w, out_w_valid, out_w_swap, out_act, out_act_valid, out_psum,
           out_psum_valid, sat_flag
  );
endinterface

// File: rtl/ws_pe_mac.sv
// Weight-stationary systolic PE: shadow/active weight pair, activation forwarding, registered MAC.
// Define WS_PE_SAT_EN to clamp the partial sum and enable the sticky sat_flag; default wraps.
module ws_pe_mac #(
  parameter int PSUM_W = 24,
  parameter int DATA_W = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  ws_pe_if.slave bus
);
  localparam int PROD_W = 2 * DATA_W;

  logic signed [DATA_W-1:0] shadow_w;
  logic signed [DATA_W-1:0] active_w;
  logic        [DATA_W-1:0] out_w_q;
  logic                     out_w_valid_q;
  logic                     out_w_swap_q;
  logic        [DATA_W-1:0] out_act_q;
  logic                     out_act_valid_q;
  logic        [PSUM_W-1:0] out_psum_q;
  logic                     out_psum_valid_q;

  logic signed [PROD_W-1:0] prod;
  logic        [PSUM_W-1:0] psum_in_eff;
  logic        [PSUM_W-1:0] psum_next;

  // 16-bit signed product holds +16384 (-128 * -128) exactly.
  assign prod        = $signed(bus.in_act) * active_w;
  assign psum_in_eff = bus.in_psum_valid ? bus.in_psum : '0;

`ifdef WS_PE_SAT_EN
  logic [PSUM_W:0] sum_ext;
  logic            sum_ovf;
  logic            sat_q;

  always_comb begin
    sum_ext   = {{(PSUM_W + 1 - PROD_W){prod[PROD_W-1]}}, prod}
              + {psum_in_eff[PSUM_W-1], psum_in_eff};
    // The extra top bit disagreeing with the PSUM_W sign bit means the sum left range.
    sum_ovf   = sum_ext[PSUM_W] ^ sum_ext[PSUM_W-1];
    psum_next = sum_ext[PSUM_W-1:0];
    if (sum_ovf) begin
      psum_next = sum_ext[PSUM_W] ? {1'b1, {(PSUM_W - 1){1'b0}}}
                                  : {1'b0, {(PSUM_W - 1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (en && bus.in_act_valid && sum_ovf) begin
      sat_q <= 1'b1;
    end
  end

  assign bus.sat_flag = sat_q;
`else
  // Wrapping modulo 2^PSUM_W is the same as dropping the carry out of an PSUM_W-bit add.
  assign psum_next    = {{(PSUM_W - PROD_W){prod[PROD_W-1]}}, prod} + psum_in_eff;
  assign bus.sat_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_w         <= '0;
      active_w         <= '0;
      out_w_q          <= '0;
      out_w_valid_q    <= 1'b0;
      out_w_swap_q     <= 1'b0;
      out_act_q        <= '0;
      out_act_valid_q  <= 1'b0;
      out_psum_q       <= '0;
      out_psum_valid_q <= 1'b0;
    end else if (en) begin
      out_w_valid_q    <= bus.in_w_valid;
      out_w_swap_q     <= bus.in_w_swap;
      out_act_q        <= bus.in_act;
      out_act_valid_q  <= bus.in_act_valid;
      out_psum_valid_q <= bus.in_act_valid;
      if (bus.in_w_valid) begin
        shadow_w <= bus.in_w;
        out_w_q  <= shadow_w;
      end
      // Swap and MAC both see the pre-edge shadow/active values.
      if (bus.in_w_swap) begin
        active_w <= shadow_w;
      end
      if (bus.in_act_valid) begin
        out_psum_q <= psum_next;
      end
    end
  end

  assign bus.out_w          = out_w_q;
  assign bus.out_w_valid    = out_w_valid_q;
  assign bus.out_w_swap     = out_w_swap_q;
  assign bus.out_act        = out_act_q;
  assign bus.out_act_valid  = out_act_valid_q;
  assign bus.out_psum       = out_psum_q;
  assign bus.out_psum_valid = out_psum_valid_q;
endmodule
